// File: rtl/oled_pkg.sv
// Shared types and constants for the SSD1306 frame sequencer: state encoding,
// command byte values and transfer lengths.
`timescale 1ns/1ps
package oled_pkg;
   typedef enum logic [2:0] {
      ST_PWRUP = 3'd0,
      ST_INIT  = 3'd1,
      ST_READY = 3'd2,
      ST_WIN   = 3'd3,
      ST_FETCH = 3'd4,
      ST_SEND  = 3'd5,
      ST_HOLD  = 3'd6
   } state_t;

   // Remembers which stream a SEND/HOLD byte belongs to, so HOLD knows where to return.
   typedef enum logic [1:0] {
      PH_INIT  = 2'd0,
      PH_WIN   = 2'd1,
      PH_FRAME = 2'd2
   } phase_t;

   localparam logic [7:0] DISP_OFF    = 8'hAE;
   localparam logic [7:0] DISP_ON     = 8'hAF;
   localparam logic [7:0] SET_COL     = 8'h21;
   localparam logic [7:0] SET_PAGE    = 8'h22;
   localparam logic [7:0] CHARGE_PUMP = 8'h8D;
   localparam logic [7:0] CMD_NOP     = 8'hE3;

   localparam int INIT_LEN = 25;
   localparam int WIN_LEN  = 6;
   localparam int FB_BYTES = 1024;
endpackage

// File: rtl/oled_cmd_rom.sv
// Command ROM: entries 0-24 hold the SSD1306 128x64 init list, 25-30 the
// full-screen address window; any other index reads as NOP.
`timescale 1ns/1ps
module oled_cmd_rom
   import oled_pkg::*;
(
   input  logic [4:0] index,
   output logic [7:0] data
);

   // Combinational lookup of one command byte.
   always_comb begin
      case (index)
         5'd0:    data = DISP_OFF;
         5'd1:    data = 8'hD5;
         5'd2:    data = 8'h80;
         5'd3:    data = 8'hA8;
         5'd4:    data = 8'h3F;
         5'd5:    data = 8'hD3;
         5'd6:    data = 8'h00;
         5'd7:    data = 8'h40;
         5'd8:    data = CHARGE_PUMP;
         5'd9:    data = 8'h14;
         5'd10:   data = 8'h20;
         5'd11:   data = 8'h00;
         5'd12:   data = 8'hA1;
         5'd13:   data = 8'hC8;
         5'd14:   data = 8'hDA;
         5'd15:   data = 8'h12;
         5'd16:   data = 8'h81;
         5'd17:   data = 8'hCF;
         5'd18:   data = 8'hD9;
         5'd19:   data = 8'hF1;
         5'd20:   data = 8'hDB;
         5'd21:   data = 8'h40;
         5'd22:   data = 8'hA4;
         5'd23:   data = 8'hA6;
         5'd24:   data = DISP_ON;
         5'd25:   data = SET_COL;
         5'd26:   data = 8'h00;
         5'd27:   data = 8'h7F;
         5'd28:   data = SET_PAGE;
         5'd29:   data = 8'h00;
         5'd30:   data = 8'h07;
         default: data = CMD_NOP;
      endcase
   end

endmodule

// File: rtl/oled_frame_sequencer.sv
// Drives a one-byte-per-transaction I2C transmitter: power-up wait, SSD1306 init
// list, then per refresh the address window followed by one framebuffer of data.
`timescale 1ns/1ps
module oled_frame_sequencer
   import oled_pkg::*;
#(
   parameter int PWRUP_WAIT = 12000
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       refresh,
   input  logic [7:0] pix_data,
   input  logic       pix_valid,
   output logic       pix_ready,
   output logic       i2c_start,
   output logic       i2c_dcn,
   output logic [7:0] i2c_data,
   input  logic       i2c_busy,
   output logic       init_done,
   output logic       frame_done,
   output logic [9:0] byte_cnt
);

   localparam int PW_W = $clog2(PWRUP_WAIT + 1);
   localparam logic [PW_W-1:0] PW_LAST = PW_W'(PWRUP_WAIT - 1);

   state_t          state_r;
   phase_t          phase_r;
   logic [PW_W-1:0] pw_cnt_r;
   logic [4:0]      idx_r;
   logic [4:0]      rom_index_s;
   logic [7:0]      rom_data_s;

   // Window commands live directly after the init list in the shared ROM.
   always_comb begin
      if (state_r == ST_WIN) begin
         rom_index_s = idx_r + 5'(INIT_LEN);
      end else begin
         rom_index_s = idx_r;
      end
   end

   oled_cmd_rom u_rom (
      .index (rom_index_s),
      .data  (rom_data_s)
   );

   // Sequencer FSM with all outputs registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= ST_PWRUP;
         phase_r    <= PH_INIT;
         pw_cnt_r   <= '0;
         idx_r      <= 5'd0;
         byte_cnt   <= 10'd0;
         i2c_start  <= 1'b0;
         i2c_dcn    <= 1'b0;
         i2c_data   <= 8'h00;
         pix_ready  <= 1'b0;
         init_done  <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         pix_ready  <= 1'b0;
         frame_done <= 1'b0;
         case (state_r)
            // A busy transmitter (byte left over from before reset) restarts the wait.
            ST_PWRUP: begin
               if (i2c_busy) begin
                  pw_cnt_r <= '0;
               end else if (pw_cnt_r == PW_LAST) begin
                  pw_cnt_r <= '0;
                  state_r  <= ST_INIT;
               end else begin
                  pw_cnt_r <= pw_cnt_r + 1'b1;
               end
            end
            ST_INIT: begin
               if (idx_r == 5'(INIT_LEN)) begin
                  init_done <= 1'b1;
                  idx_r     <= 5'd0;
                  state_r   <= ST_READY;
               end else begin
                  i2c_data  <= rom_data_s;
                  i2c_dcn   <= 1'b0;
                  i2c_start <= 1'b1;
                  phase_r   <= PH_INIT;
                  state_r   <= ST_SEND;
               end
            end
            ST_READY: begin
               if (refresh) begin
                  idx_r   <= 5'd0;
                  state_r <= ST_WIN;
               end
            end
            ST_WIN: begin
               if (idx_r == 5'(WIN_LEN)) begin
                  idx_r    <= 5'd0;
                  byte_cnt <= 10'd0;
                  state_r  <= ST_FETCH;
               end else begin
                  i2c_data  <= rom_data_s;
                  i2c_dcn   <= 1'b0;
                  i2c_start <= 1'b1;
                  phase_r   <= PH_WIN;
                  state_r   <= ST_SEND;
               end
            end
            ST_FETCH: begin
               if (pix_valid) begin
                  i2c_data  <= pix_data;
                  i2c_dcn   <= 1'b1;
                  i2c_start <= 1'b1;
                  pix_ready <= 1'b1;
                  phase_r   <= PH_FRAME;
                  state_r   <= ST_SEND;
               end
            end
            ST_SEND: begin
               if (i2c_busy) begin
                  i2c_start <= 1'b0;
                  state_r   <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (!i2c_busy) begin
                  case (phase_r)
                     PH_INIT: begin
                        idx_r   <= idx_r + 5'd1;
                        state_r <= ST_INIT;
                     end
                     PH_WIN: begin
                        idx_r   <= idx_r + 5'd1;
                        state_r <= ST_WIN;
                     end
                     PH_FRAME: begin
                        if (byte_cnt == 10'(FB_BYTES - 1)) begin
                           frame_done <= 1'b1;
                           byte_cnt   <= 10'd0;
                           state_r    <= ST_READY;
                        end else begin
                           byte_cnt <= byte_cnt + 10'd1;
                           state_r  <= ST_FETCH;
                        end
                     end
                     default: state_r <= ST_PWRUP;
                  endcase
               end
            end
            default: begin
               i2c_start <= 1'b0;
               state_r   <= ST_PWRUP;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_oled_frame_sequencer.sv
// Scoreboard bench: stimulus pushes expected {dcn,data} transactions, a monitor
// pops and compares on every rising i2c_start against a behavioural transmitter.
`timescale 1ns/1ps
module tb_oled_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       refresh = 1'b0;
   logic [7:0] pix_data = 8'h00;
   logic       pix_valid = 1'b0;
   logic       pix_ready;
   logic       i2c_start;
   logic       i2c_dcn;
   logic [7:0] i2c_data;
   logic       i2c_busy = 1'b0;
   logic       init_done;
   logic       frame_done;
   logic [9:0] byte_cnt;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];
   int n_starts = 0;
   int n_fd = 0;
   int n_pr = 0;
   int fd_mark = 25;
   int busy_len = 40;
   int src_cnt = 0;
   int stall_at = -1;

   logic [7:0] init_tab [25] = '{8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
                                 8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
                                 8'h81, 8'hCF, 8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6,
                                 8'hAF};
   logic [7:0] win_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

   always #5 clk = ~clk;

   oled_frame_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .refresh    (refresh),
      .pix_data   (pix_data),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .i2c_start  (i2c_start),
      .i2c_dcn    (i2c_dcn),
      .i2c_data   (i2c_data),
      .i2c_busy   (i2c_busy),
      .init_done  (init_done),
      .frame_done (frame_done),
      .byte_cnt   (byte_cnt)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic push_init();
      for (int i = 0; i < 25; i++) exp_q.push_back({1'b0, init_tab[i]});
   endtask

   task automatic push_frame();
      logic [9:0] k;
      for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, win_tab[i]});
      for (int i = 0; i < 1024; i++) begin
         k = 10'(i);
         exp_q.push_back({1'b1, k[7:0]});
      end
   endtask

   task automatic pulse_refresh();
      refresh = 1'b1;
      @(negedge clk);
      refresh = 1'b0;
   endtask

   task automatic wait_init(input int target);
      int t;
      t = 0;
      while (!init_done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("init_done_rise", int'(init_done), 1);
      chk("init_txn_count", n_starts, target);
      chk("init_busy_low", int'(i2c_busy), 0);
   endtask

   task automatic wait_fd(input int target, input int bound);
      int t;
      t = 0;
      while (n_fd < target && t < bound) begin
         @(negedge clk);
         t++;
      end
      chk("frame_done_count", n_fd, target);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_start"}, int'(i2c_start), 0);
      chk({tag, "_dcn"}, int'(i2c_dcn), 0);
      chk({tag, "_data"}, int'(i2c_data), 0);
      chk({tag, "_pix_ready"}, int'(pix_ready), 0);
      chk({tag, "_init_done"}, int'(init_done), 0);
      chk({tag, "_frame_done"}, int'(frame_done), 0);
      chk({tag, "_byte_cnt"}, int'(byte_cnt), 0);
   endtask

   // Transmitter model: busy rises a few cycles after start, stays high busy_len cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (i2c_start && !i2c_busy) begin
            repeat (2) @(negedge clk);
            i2c_busy = 1'b1;
            repeat (busy_len) @(negedge clk);
            i2c_busy = 1'b0;
         end
      end
   end

   // Pixel source: pix_data follows the count of consumed bytes; optional stall.
   initial begin
      int stall_base;
      forever begin
         @(negedge clk);
         if (pix_ready) begin
            src_cnt++;
            pix_data = src_cnt[7:0];
            if (src_cnt == stall_at) begin
               pix_valid = 1'b0;
               repeat (100) @(negedge clk);
               stall_base = n_starts;
               repeat (400) @(negedge clk);
               chk("stall_no_new_start", n_starts, stall_base);
               chk("stall_start_low", int'(i2c_start), 0);
               pix_valid = 1'b1;
            end
         end
      end
   end

   // Monitor: scoreboard pop on each new transaction plus handshake checks.
   initial begin
      logic       start_q;
      logic       busy_q;
      logic       pr_q;
      logic       dcn_q;
      logic [7:0] data_q;
      logic [8:0] got;
      start_q = 1'b0;
      busy_q  = 1'b0;
      pr_q    = 1'b0;
      dcn_q   = 1'b0;
      data_q  = 8'h00;
      forever begin
         @(negedge clk);
         if (i2c_start && !start_q) begin
            n_starts++;
            got = {i2c_dcn, i2c_data};
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_underflow: got txn 0x%03h, expected no transaction", got);
            end else begin
               chk("sb_txn", int'(got), int'(exp_q.pop_front()));
            end
         end
         if (i2c_start && start_q) begin
            chk("dcn_stable", int'(i2c_dcn), int'(dcn_q));
            chk("data_stable", int'(i2c_data), int'(data_q));
         end
         if (start_q && !i2c_start && !rst) chk("start_held_until_busy", int'(i2c_busy), 1);
         if (busy_q) chk("start_low_in_hold", int'(i2c_start), 0);
         if (frame_done) begin
            n_fd++;
            chk("frame_txn_count", n_starts - fd_mark, 1030);
            fd_mark = n_starts;
         end
         if (pix_ready) begin
            n_pr++;
            chk("pix_ready_one_cycle", int'(pr_q), 0);
         end
         start_q = i2c_start;
         busy_q  = i2c_busy;
         pr_q    = pix_ready;
         dcn_q   = i2c_dcn;
         data_q  = i2c_data;
      end
   end

   // Directed scenario sequence.
   initial begin
      int t;
      int base;
      repeat (5) @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b0;
      push_init();
      repeat (11999) @(negedge clk);
      chk("pwrup_no_start", n_starts, 0);
      wait_init(25);

      busy_len  = 4;
      pix_valid = 1'b1;
      push_frame();
      pulse_refresh();
      wait_fd(1, 15000);
      chk("frame1_pix_ready", n_pr, 1024);
      chk("frame1_queue_empty", exp_q.size(), 0);
      chk("frame1_byte_cnt_clear", int'(byte_cnt), 0);

      stall_at = 1024 + 300;
      push_frame();
      pulse_refresh();
      wait_fd(2, 16000);
      chk("frame2_pix_ready", n_pr, 2048);
      chk("frame2_queue_empty", exp_q.size(), 0);

      push_frame();
      push_frame();
      refresh = 1'b1;
      wait_fd(3, 15000);
      repeat (50) @(negedge clk);
      refresh = 1'b0;
      wait_fd(4, 15000);
      repeat (100) @(negedge clk);
      chk("b2b_total_txns", n_starts, 25 + 4 * 1030);
      chk("b2b_queue_empty", exp_q.size(), 0);
      chk("b2b_pix_ready", n_pr, 4096);
      chk("init_done_held", int'(init_done), 1);

      push_frame();
      pulse_refresh();
      t = 0;
      while (!(i2c_busy && byte_cnt == 10'd10) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      chk("midframe_point_reached", int'(i2c_busy && byte_cnt == 10'd10), 1);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_outputs("midframe_reset");
      rst = 1'b0;
      exp_q.delete();
      push_init();
      base = n_starts;
      t = 0;
      while (i2c_busy && t < 100) begin
         @(negedge clk);
         t++;
      end
      repeat (11999) @(negedge clk);
      chk("repwrup_no_start", n_starts, base);
      wait_init(base + 25);
      chk("reinit_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
